asm_backpatch_encoder: RTL and testbench

Single-pass RV32I encoding back end. It accepts decoded instruction fields one line at a time and packs them into 32-bit words in an internal program buffer. Label definitions and references arrive in any order: backward references resolve immediately, forward references are recorded in a fixup table and patched after end of program. The finished image then streams out over a valid/ready port. This replaces the separate PC_MAPPING pre-pass and removes the fixed label-size and single-channel limits of the current assembler.

---
 rtl/asm_backpatch_encoder.sv | 338 +++++++++++++++++++++++++++++++++
 tb/tb_asm_backpatch_encoder.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/asm_backpatch_encoder.sv
// rtl/asm_backpatch_encoder.sv - single-pass RV32I encoder with forward-label backpatching
//
// Purpose: packs decoded RV32I fields into a word buffer. Backward label references
// resolve at once. Forward references are queued and patched after end_of_program.
// The finished image is then streamed out.
// Ports:
//   clk_in, rst_in                       clock, synchronous active-high reset
//   fields_valid/fields_ready            instruction field handshake
//   opcode..imm, uses_label, label_ref   instruction fields and label reference
//   label_def, label_def_id              define a label at the current pc
//   end_of_program                       strobe, no more input
//   out_valid/out_ready/out_word/out_addr  image stream
//   done_flag, error_flag, error_code    status
module asm_backpatch_encoder #(
    parameter int NUMBER_LINES = 256,
    parameter int NUM_LABELS   = 16,
    parameter int NUM_FIXUPS   = 16
) (
    input  logic                            clk_in,
    input  logic                            rst_in,
    input  logic                            fields_valid,
    output logic                            fields_ready,
    input  logic [6:0]                      opcode,
    input  logic [2:0]                      funct3,
    input  logic [6:0]                      funct7,
    input  logic [4:0]                      rd,
    input  logic [4:0]                      rs1,
    input  logic [4:0]                      rs2,
    input  logic [31:0]                     imm,
    input  logic                            uses_label,
    input  logic [$clog2(NUM_LABELS)-1:0]   label_ref,
    input  logic                            label_def,
    input  logic [$clog2(NUM_LABELS)-1:0]   label_def_id,
    input  logic                            end_of_program,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [31:0]                     out_word,
    output logic [$clog2(NUMBER_LINES)-1:0] out_addr,
    output logic                            done_flag,
    output logic                            error_flag,
    output logic [2:0]                      error_code
);
    localparam int AW = $clog2(NUMBER_LINES);
    localparam int LW = $clog2(NUM_LABELS);
    localparam int FW = $clog2(NUM_FIXUPS);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    typedef enum logic [2:0] {S_ACCEPT, S_PATCH_A, S_PATCH_B, S_STREAM, S_DONE, S_ERROR} state_t;

    function automatic logic [31:0] b_imm(input logic [31:0] o);
        return {o[12], o[10:5], 13'b0, o[4:1], o[11], 7'b0};
    endfunction

    function automatic logic [31:0] j_imm(input logic [31:0] o);
        return {o[20], o[10:1], o[11], o[19:12], 12'b0};
    endfunction

    // Byte offset from the referencing word to the label, two's complement.
    function automatic logic [31:0] word_offset(input logic [AW:0] target, input logic [AW:0] from);
        logic [31:0] d;
        d = 32'(target) - 32'(from);
        return d << 2;
    endfunction

    function automatic logic in_range(input logic is_jal, input logic [31:0] off);
        logic signed [31:0] s;
        s = $signed(off);
        if (is_jal) return (s >= -32'sd1048576) && (s <= 32'sd1048574);
        return (s >= -32'sd4096) && (s <= 32'sd4094);
    endfunction

    function automatic logic supported(input logic [6:0] op);
        case (op)
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH,
            OP_LOAD, OP_STORE, OP_IMM, OP_REG: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] encode(input logic [6:0] op, input logic [2:0] f3,
                                           input logic [6:0] f7, input logic [4:0] d,
                                           input logic [4:0] s1, input logic [4:0] s2,
                                           input logic [31:0] im);
        logic [11:0] i12;
        i12 = im[11:0];
        case (op)
            OP_REG:    return {f7, s2, s1, f3, d, op};
            OP_IMM: begin
                // shift-immediate forms carry funct7 in the upper immediate bits
                if (f3 == 3'b001 || f3 == 3'b101) i12[11:5] = i12[11:5] | f7;
                return {i12, s1, f3, d, op};
            end
            OP_LOAD, OP_JALR: return {i12, s1, f3, d, op};
            OP_STORE:  return {im[11:5], s2, s1, f3, im[4:0], op};
            OP_BRANCH: return b_imm(im) | {7'b0, s2, s1, f3, 5'b0, op};
            OP_LUI, OP_AUIPC: return {im[19:0], d, op};
            OP_JAL:    return j_imm(im) | {20'b0, d, op};
            default:   return 32'b0;
        endcase
    endfunction

    state_t              state_q, state_d;
    logic [AW:0]         pc_q, pc_d;
    logic                lbl_def_q [NUM_LABELS];
    logic                lbl_def_d [NUM_LABELS];
    logic [AW:0]         lbl_pc_q  [NUM_LABELS];
    logic [AW:0]         lbl_pc_d  [NUM_LABELS];
    logic [AW-1:0]       fix_pc_q  [NUM_FIXUPS];
    logic [AW-1:0]       fix_pc_d  [NUM_FIXUPS];
    logic [LW-1:0]       fix_lbl_q [NUM_FIXUPS];
    logic [LW-1:0]       fix_lbl_d [NUM_FIXUPS];
    logic [FW:0]         fix_cnt_q, fix_cnt_d;
    logic [FW:0]         pidx_q, pidx_d;
    logic [31:0]         pword_q, pword_d;
    logic [AW-1:0]       paddr_q, paddr_d;
    logic                plbl_def_q, plbl_def_d;
    logic [AW:0]         plbl_pc_q, plbl_pc_d;
    logic                out_valid_q, out_valid_d;
    logic [31:0]         out_word_q, out_word_d;
    logic [AW-1:0]       out_addr_q, out_addr_d;
    logic                done_q, done_d;
    logic                err_flag_q, err_flag_d;
    logic [2:0]          err_code_q, err_code_d;

    logic [31:0]         mem [NUMBER_LINES];
    logic                wr_en;
    logic [AW-1:0]       wr_addr;
    logic [31:0]         wr_data;

    logic                full, hs, ref_def, p_is_jal;
    logic [AW:0]         ref_pc;
    logic [31:0]         off, imm_eff;
    logic [2:0]          new_err;

    // pc counts written words, so the top bit marks a completely filled buffer
    assign full         = pc_q[AW];
    assign fields_ready = (state_q == S_ACCEPT) && !full;
    assign hs           = fields_valid && fields_ready && !end_of_program;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        lbl_def_d   = lbl_def_q;
        lbl_pc_d    = lbl_pc_q;
        fix_pc_d    = fix_pc_q;
        fix_lbl_d   = fix_lbl_q;
        fix_cnt_d   = fix_cnt_q;
        pidx_d      = pidx_q;
        pword_d     = pword_q;
        paddr_d     = paddr_q;
        plbl_def_d  = plbl_def_q;
        plbl_pc_d   = plbl_pc_q;
        out_valid_d = out_valid_q;
        out_word_d  = out_word_q;
        out_addr_d  = out_addr_q;
        done_d      = done_q;
        err_flag_d  = err_flag_q;
        err_code_d  = err_code_q;
        wr_en       = 1'b0;
        wr_addr     = '0;
        wr_data     = '0;
        ref_def     = 1'b0;
        ref_pc      = '0;
        off         = '0;
        imm_eff     = '0;
        p_is_jal    = 1'b0;
        new_err     = 3'd0;

        case (state_q)
            S_ACCEPT: begin
                if (end_of_program) begin
                    if (fix_cnt_q != '0) begin
                        state_d = S_PATCH_A;
                        pidx_d  = '0;
                    end else if (pc_q == '0) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d     = S_STREAM;
                        out_valid_d = 1'b1;
                        out_addr_d  = '0;
                        out_word_d  = mem[0];
                    end
                end else begin
                    if (label_def) begin
                        if (lbl_def_q[label_def_id]) begin
                            new_err = 3'd3;
                        end else begin
                            lbl_def_d[label_def_id] = 1'b1;
                            lbl_pc_d[label_def_id]  = pc_q;
                        end
                    end
                    if (fields_valid && full && new_err == 3'd0) new_err = 3'd1;
                    if (hs && new_err == 3'd0) begin
                        // lookup through the _d copy so a same-cycle definition is visible
                        ref_def = lbl_def_d[label_ref];
                        ref_pc  = lbl_pc_d[label_ref];
                        off     = word_offset(ref_pc, pc_q);
                        if (!supported(opcode)) begin
                            new_err = 3'd7;
                        end else if (uses_label && opcode != OP_BRANCH && opcode != OP_JAL) begin
                            new_err = 3'd6;
                        end else if (uses_label && ref_def && !in_range(opcode == OP_JAL, off)) begin
                            new_err = 3'd5;
                        end else if (uses_label && !ref_def && fix_cnt_q == (FW+1)'(NUM_FIXUPS)) begin
                            new_err = 3'd2;
                        end else begin
                            imm_eff = !uses_label ? imm : (ref_def ? off : 32'b0);
                            wr_en   = 1'b1;
                            wr_addr = pc_q[AW-1:0];
                            wr_data = encode(opcode, funct3, funct7, rd, rs1, rs2, imm_eff);
                            pc_d    = pc_q + (AW+1)'(1);
                            if (uses_label && !ref_def) begin
                                fix_pc_d[fix_cnt_q[FW-1:0]]  = pc_q[AW-1:0];
                                fix_lbl_d[fix_cnt_q[FW-1:0]] = label_ref;
                                fix_cnt_d = fix_cnt_q + (FW+1)'(1);
                            end
                        end
                    end
                end
            end
            S_PATCH_A: begin
                paddr_d    = fix_pc_q[pidx_q[FW-1:0]];
                pword_d    = mem[fix_pc_q[pidx_q[FW-1:0]]];
                plbl_def_d = lbl_def_q[fix_lbl_q[pidx_q[FW-1:0]]];
                plbl_pc_d  = lbl_pc_q[fix_lbl_q[pidx_q[FW-1:0]]];
                state_d    = S_PATCH_B;
            end
            S_PATCH_B: begin
                p_is_jal = (pword_q[6:0] == OP_JAL);
                off      = word_offset(plbl_pc_q, {1'b0, paddr_q});
                if (!plbl_def_q) begin
                    new_err = 3'd4;
                end else if (!in_range(p_is_jal, off)) begin
                    new_err = 3'd5;
                end else begin
                    wr_en   = 1'b1;
                    wr_addr = paddr_q;
                    wr_data = pword_q | (p_is_jal ? j_imm(off) : b_imm(off));
                    if (pidx_q + (FW+1)'(1) == fix_cnt_q) begin
                        state_d     = S_STREAM;
                        out_valid_d = 1'b1;
                        out_addr_d  = '0;
                        // word 0 may be the one being patched on this same edge
                        out_word_d  = (paddr_q == '0) ? wr_data : mem[0];
                    end else begin
                        pidx_d  = pidx_q + (FW+1)'(1);
                        state_d = S_PATCH_A;
                    end
                end
            end
            S_STREAM: begin
                if (out_ready) begin
                    if ((AW+1)'(out_addr_q) == pc_q - (AW+1)'(1)) begin
                        out_valid_d = 1'b0;
                        done_d      = 1'b1;
                        state_d     = S_DONE;
                    end else begin
                        out_addr_d = out_addr_q + AW'(1);
                        out_word_d = mem[out_addr_q + AW'(1)];
                    end
                end
            end
            default: begin
            end
        endcase

        if (new_err != 3'd0) begin
            state_d     = S_ERROR;
            err_flag_d  = 1'b1;
            err_code_d  = new_err;
            out_valid_d = 1'b0;
            wr_en       = 1'b0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in && wr_en) mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q     <= S_ACCEPT;
            pc_q        <= '0;
            lbl_def_q   <= '{default: 1'b0};
            lbl_pc_q    <= '{default: '0};
            fix_pc_q    <= '{default: '0};
            fix_lbl_q   <= '{default: '0};
            fix_cnt_q   <= '0;
            pidx_q      <= '0;
            pword_q     <= '0;
            paddr_q     <= '0;
            plbl_def_q  <= 1'b0;
            plbl_pc_q   <= '0;
            out_valid_q <= 1'b0;
            out_word_q  <= '0;
            out_addr_q  <= '0;
            done_q      <= 1'b0;
            err_flag_q  <= 1'b0;
            err_code_q  <= 3'd0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            lbl_def_q   <= lbl_def_d;
            lbl_pc_q    <= lbl_pc_d;
            fix_pc_q    <= fix_pc_d;
            fix_lbl_q   <= fix_lbl_d;
            fix_cnt_q   <= fix_cnt_d;
            pidx_q      <= pidx_d;
            pword_q     <= pword_d;
            paddr_q     <= paddr_d;
            plbl_def_q  <= plbl_def_d;
            plbl_pc_q   <= plbl_pc_d;
            out_valid_q <= out_valid_d;
            out_word_q  <= out_word_d;
            out_addr_q  <= out_addr_d;
            done_q      <= done_d;
            err_flag_q  <= err_flag_d;
            err_code_q  <= err_code_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_word   = out_word_q;
    assign out_addr   = out_addr_q;
    assign done_flag  = done_q;
    assign error_flag = err_flag_q;
    assign error_code = err_code_q;
endmodule

// File: tb/tb_asm_backpatch_encoder.sv
// tb/tb_asm_backpatch_encoder.sv - directed bench for asm_backpatch_encoder
module tb_asm_backpatch_encoder;
    logic        clk = 1'b0;
    logic        rst_in;
    logic        fields_valid;
    logic        fields_ready;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    logic        uses_label;
    logic [3:0]  label_ref;
    logic        label_def;
    logic [3:0]  label_def_id;
    logic        end_of_program;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_word;
    logic [10:0] out_addr;
    logic        done_flag;
    logic        error_flag;
    logic [2:0]  error_code;

    localparam logic [31:0] W_ADDI1    = 32'h00100093;
    localparam logic [31:0] W_ADDI2    = 32'h00100113;
    localparam logic [31:0] W_ADDI3    = 32'h00100193;
    localparam logic [31:0] W_BEQ_BACK = 32'hFE208CE3;
    localparam logic [31:0] W_JAL_FWD  = 32'h00C000EF;
    localparam logic [31:0] W_JAL_ZERO = 32'h000000EF;

    int          n_vec = 0;
    int          n_fail = 0;
    logic [31:0] got_w [16];
    logic [10:0] got_a [16];
    int          got_n;

    always #5 clk = ~clk;

    asm_backpatch_encoder #(.NUMBER_LINES(2048), .NUM_LABELS(16), .NUM_FIXUPS(16)) dut (
        .clk_in(clk), .rst_in(rst_in), .fields_valid(fields_valid), .fields_ready(fields_ready),
        .opcode(opcode), .funct3(funct3), .funct7(funct7), .rd(rd), .rs1(rs1), .rs2(rs2),
        .imm(imm), .uses_label(uses_label), .label_ref(label_ref), .label_def(label_def),
        .label_def_id(label_def_id), .end_of_program(end_of_program), .out_valid(out_valid),
        .out_ready(out_ready), .out_word(out_word), .out_addr(out_addr), .done_flag(done_flag),
        .error_flag(error_flag), .error_code(error_code)
    );

    task automatic do_reset();
        rst_in = 1'b1; fields_valid = 1'b0; uses_label = 1'b0; label_def = 1'b0;
        end_of_program = 1'b0; out_ready = 1'b0;
        @(posedge clk); #1;
        rst_in = 1'b0;
    endtask

    task automatic send(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                        input logic [31:0] im, input logic ul, input logic [3:0] lr,
                        input logic ld, input logic [3:0] lid);
        opcode = op; funct3 = f3; funct7 = f7; rd = d; rs1 = s1; rs2 = s2; imm = im;
        uses_label = ul; label_ref = lr; label_def = ld; label_def_id = lid;
        fields_valid = 1'b1;
        @(posedge clk); #1;
        fields_valid = 1'b0; uses_label = 1'b0; label_def = 1'b0;
    endtask

    task automatic addi(input logic [4:0] r, input logic ld, input logic [3:0] lid);
        send(7'h13, 3'd0, 7'd0, r, 5'd0, 5'd0, 32'd1, 1'b0, 4'd0, ld, lid);
    endtask

    task automatic beq_lbl(input logic [3:0] lr);
        send(7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd0, 1'b1, lr, 1'b0, 4'd0);
    endtask

    task automatic eop();
        end_of_program = 1'b1;
        @(posedge clk); #1;
        end_of_program = 1'b0;
    endtask

    task automatic collect(input int n, input int budget);
        got_n = 0;
        out_ready = 1'b1;
        for (int c = 0; c < budget && got_n < n; c++) begin
            if (out_valid) begin
                got_w[got_n] = out_word;
                got_a[got_n] = out_addr;
                got_n++;
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++; if (fields_ready !== 1'b1) begin n_fail++; $display("FAIL rst_fields_ready got %b exp 1", fields_ready); end
        n_vec++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
        n_vec++; if (out_word !== 32'd0) begin n_fail++; $display("FAIL rst_out_word got %h exp 0", out_word); end
        n_vec++; if (out_addr !== 11'd0) begin n_fail++; $display("FAIL rst_out_addr got %0d exp 0", out_addr); end
        n_vec++; if (done_flag !== 1'b0) begin n_fail++; $display("FAIL rst_done got %b exp 0", done_flag); end
        n_vec++; if (error_flag !== 1'b0) begin n_fail++; $display("FAIL rst_error_flag got %b exp 0", error_flag); end
        n_vec++; if (error_code !== 3'd0) begin n_fail++; $display("FAIL rst_error_code got %0d exp 0", error_code); end
    endtask

    task automatic load_backward();
        do_reset();
        addi(5'd1, 1'b1, 4'd0);
        addi(5'd2, 1'b0, 4'd0);
        beq_lbl(4'd0);
        eop();
    endtask

    task automatic test_backward_branch();
        logic [31:0] exp_w [3];
        exp_w = '{W_ADDI1, W_ADDI2, W_BEQ_BACK};
        load_backward();
        collect(3, 20);
        n_vec++; if (got_n != 3) begin n_fail++; $display("FAIL bb_count got %0d exp 3", got_n); end
        for (int i = 0; i < got_n && i < 3; i++) begin
            n_vec++; if (got_w[i] !== exp_w[i]) begin n_fail++; $display("FAIL bb_word%0d got %h exp %h", i, got_w[i], exp_w[i]); end
            n_vec++; if (got_a[i] !== 11'(i)) begin n_fail++; $display("FAIL bb_addr%0d got %0d exp %0d", i, got_a[i], i); end
        end
        n_vec++; if (done_flag !== 1'b1) begin n_fail++; $display("FAIL bb_done got %b exp 1", done_flag); end
        n_vec++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bb_valid_after got %b exp 0", out_valid); end
    endtask

    task automatic test_forward_jal();
        logic [31:0] exp_w [4];
        int lat;
        exp_w = '{W_JAL_FWD, W_ADDI1, W_ADDI2, W_ADDI3};
        do_reset();
        send(7'h6F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd0, 1'b1, 4'd1, 1'b0, 4'd0);
        addi(5'd1, 1'b0, 4'd0);
        addi(5'd2, 1'b0, 4'd0);
        addi(5'd3, 1'b1, 4'd1);
        eop();
        lat = 0;
        while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        n_vec++; if (lat != 2) begin n_fail++; $display("FAIL fj_patch_cycles got %0d exp 2", lat); end
        collect(4, 20);
        n_vec++; if (got_n != 4) begin n_fail++; $display("FAIL fj_count got %0d exp 4", got_n); end
        for (int i = 0; i < got_n && i < 4; i++) begin
            n_vec++; if (got_w[i] !== exp_w[i]) begin n_fail++; $display("FAIL fj_word%0d got %h exp %h", i, got_w[i], exp_w[i]); end
        end
        n_vec++; if (done_flag !== 1'b1) begin n_fail++; $display("FAIL fj_done got %b exp 1", done_flag); end
    endtask

    task automatic test_backpressure();
        logic [7:0]  pat;
        logic        prev_stall;
        logic [31:0] prev_w;
        logic [10:0] prev_a;
        logic [31:0] exp_w [3];
        exp_w = '{W_ADDI1, W_ADDI2, W_BEQ_BACK};
        pat = 8'b1111_1001;
        load_backward();
        got_n = 0; prev_stall = 1'b0; prev_w = '0; prev_a = '0;
        for (int c = 0; c < 20 && got_n < 3; c++) begin
            out_ready = (c < 8) ? pat[c] : 1'b1;
            if (out_valid) begin
                if (prev_stall) begin
                    n_vec++;
                    if (out_word !== prev_w || out_addr !== prev_a) begin
                        n_fail++;
                        $display("FAIL bp_stable got %h@%0d exp %h@%0d", out_word, out_addr, prev_w, prev_a);
                    end
                end
                if (out_ready) begin got_w[got_n] = out_word; got_a[got_n] = out_addr; got_n++; end
            end
            prev_stall = out_valid && !out_ready; prev_w = out_word; prev_a = out_addr;
            @(posedge clk); #1;
        end
        out_ready = 1'b0;
        n_vec++; if (got_n != 3) begin n_fail++; $display("FAIL bp_count got %0d exp 3", got_n); end
        for (int i = 0; i < got_n && i < 3; i++) begin
            n_vec++;
            if (got_w[i] !== exp_w[i] || got_a[i] !== 11'(i)) begin
                n_fail++; $display("FAIL bp_word%0d got %h@%0d exp %h@%0d", i, got_w[i], got_a[i], exp_w[i], i);
            end
        end
    endtask

    task automatic test_reset_mid_stream();
        load_backward();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        rst_in = 1'b1;
        @(posedge clk); #1;
        rst_in = 1'b0;
        n_vec++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rm_valid got %b exp 0", out_valid); end
        n_vec++; if (out_word !== 32'd0) begin n_fail++; $display("FAIL rm_word got %h exp 0", out_word); end
        n_vec++; if (out_addr !== 11'd0) begin n_fail++; $display("FAIL rm_addr got %0d exp 0", out_addr); end
        n_vec++; if (fields_ready !== 1'b1) begin n_fail++; $display("FAIL rm_ready got %b exp 1", fields_ready); end
        send(7'h6F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd0, 1'b1, 4'd0, 1'b1, 4'd0);
        eop();
        collect(1, 10);
        n_vec++; if (got_n != 1) begin n_fail++; $display("FAIL rm_count got %0d exp 1", got_n); end
        n_vec++; if (got_w[0] !== W_JAL_ZERO || got_a[0] !== 11'd0) begin n_fail++; $display("FAIL rm_word0 got %h@%0d exp %h@0", got_w[0], got_a[0], W_JAL_ZERO); end
        n_vec++; if (error_flag !== 1'b0 || done_flag !== 1'b1) begin n_fail++; $display("FAIL rm_status got err=%b done=%b exp err=0 done=1", error_flag, done_flag); end
    endtask

    task automatic test_error_redefine();
        do_reset();
        addi(5'd1, 1'b1, 4'd2);
        addi(5'd2, 1'b1, 4'd2);
        n_vec++; if (error_code !== 3'd3) begin n_fail++; $display("FAIL redef_code got %0d exp 3", error_code); end
        n_vec++; if (error_flag !== 1'b1) begin n_fail++; $display("FAIL redef_flag got %b exp 1", error_flag); end
        n_vec++; if (fields_ready !== 1'b0) begin n_fail++; $display("FAIL redef_ready got %b exp 0", fields_ready); end
    endtask

    task automatic test_error_undefined();
        int seen;
        do_reset();
        beq_lbl(4'd5);
        addi(5'd1, 1'b0, 4'd0);
        eop();
        out_ready = 1'b1;
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            if (out_valid) seen++;
            @(posedge clk); #1;
        end
        out_ready = 1'b0;
        n_vec++; if (seen != 0) begin n_fail++; $display("FAIL undef_valid got %0d cycles exp 0", seen); end
        n_vec++; if (error_code !== 3'd4) begin n_fail++; $display("FAIL undef_code got %0d exp 4", error_code); end
    endtask

    task automatic test_error_opcodes();
        do_reset();
        send(7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd0, 1'b1, 4'd0, 1'b0, 4'd0);
        n_vec++; if (error_code !== 3'd6) begin n_fail++; $display("FAIL lblop_code got %0d exp 6", error_code); end
        do_reset();
        send(7'h7F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd0, 1'b0, 4'd0, 1'b0, 4'd0);
        n_vec++; if (error_code !== 3'd7) begin n_fail++; $display("FAIL badop_code got %0d exp 7", error_code); end
    endtask

    task automatic test_range();
        do_reset();
        addi(5'd1, 1'b1, 4'd0);
        for (int i = 1; i < 1024; i++) addi(5'd1, 1'b0, 4'd0);
        beq_lbl(4'd0);
        n_vec++; if (error_flag !== 1'b0) begin n_fail++; $display("FAIL range_edge got err=%b code=%0d exp err=0", error_flag, error_code); end
        for (int i = 1025; i < 1100; i++) addi(5'd1, 1'b0, 4'd0);
        beq_lbl(4'd0);
        n_vec++; if (error_code !== 3'd5) begin n_fail++; $display("FAIL range_code got %0d exp 5", error_code); end
    endtask

    task automatic test_fixup_overflow();
        do_reset();
        for (int i = 0; i < 16; i++) beq_lbl(4'd7);
        n_vec++; if (error_flag !== 1'b0) begin n_fail++; $display("FAIL fix16_flag got %b exp 0", error_flag); end
        beq_lbl(4'd7);
        n_vec++; if (error_code !== 3'd2) begin n_fail++; $display("FAIL fix17_code got %0d exp 2", error_code); end
    endtask

    task automatic test_buffer_full();
        do_reset();
        for (int i = 0; i < 2048; i++) addi(5'd1, 1'b0, 4'd0);
        n_vec++; if (fields_ready !== 1'b0 || error_flag !== 1'b0) begin n_fail++; $display("FAIL full_ready got ready=%b err=%b exp ready=0 err=0", fields_ready, error_flag); end
        addi(5'd1, 1'b0, 4'd0);
        n_vec++; if (error_code !== 3'd1) begin n_fail++; $display("FAIL full_code got %0d exp 1", error_code); end
    endtask

    initial begin
        rst_in = 1'b1; fields_valid = 1'b0; opcode = '0; funct3 = '0; funct7 = '0;
        rd = '0; rs1 = '0; rs2 = '0; imm = '0; uses_label = 1'b0; label_ref = '0;
        label_def = 1'b0; label_def_id = '0; end_of_program = 1'b0; out_ready = 1'b0;
        test_reset();
        test_backward_branch();
        test_forward_jal();
        test_backpressure();
        test_reset_mid_stream();
        test_error_redefine();
        test_error_undefined();
        test_error_opcodes();
        test_range();
        test_fixup_overflow();
        test_buffer_full();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
